// File: rtl/ring_rr_arbiter_pkg.sv
// ring_rr_arbiter_pkg
// Shared types and helpers for the ring round-robin arbiter.
// Contents:
//   arb_state_t  two-state FSM encoding (ST_IDLE, ST_BUSY)
//   MAX_NREQ     widest requester vector the helpers operate on
//   rotl1        rotate a one-hot vector left by one inside an n-bit ring
//   onehot2bin   binary index of the lowest set bit (0 when the vector is zero)
package ring_rr_arbiter_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } arb_state_t;

   localparam int MAX_NREQ = 32;

   // Rotation is done on a fixed-width container so callers of any ring size
   // can share it; bits at and above position n are masked away, which also
   // discards the bit shifted out of the top of the ring.
   function automatic logic [MAX_NREQ-1:0] rotl1(input logic [MAX_NREQ-1:0] v, input int n);
      logic [MAX_NREQ-1:0] mask;
      mask = (MAX_NREQ'(1) << n) - MAX_NREQ'(1);
      return ((v << 1) | (v >> (n - 1))) & mask;
   endfunction

   // Scanning downward means the lowest set bit is the last one written,
   // so a stray multi-hot input still yields a defined index.
   function automatic int onehot2bin(input logic [MAX_NREQ-1:0] v);
      int idx;
      idx = 0;
      for (int i = MAX_NREQ - 1; i >= 0; i--) begin
         if (v[i]) begin
            idx = i;
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/ring_rr_arbiter_token.sv
// ring_rr_arbiter_token
// One-hot rotating priority token. Comes out of reset pointing at requester 0
// and, when told to advance, moves to the position just past the releasing
// owner (wrapping from the top requester back to requester 0).
// Ports:
//   clk      rising-edge clock
//   reset    synchronous, active-high; token returns to bit 0
//   advance  one-cycle strobe: move the token past owner
//   owner    one-hot vector of the owner that is releasing
//   token    current one-hot priority token
module ring_rr_arbiter_token
   import ring_rr_arbiter_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            advance,
   input  logic [NREQ-1:0] owner,
   output logic [NREQ-1:0] token
);

   logic [NREQ-1:0] token_next;

   // The new token is derived from the owner rather than from the old token,
   // because the owner may sit anywhere ahead of the token when it was chosen.
   always_comb begin
      token_next = NREQ'(rotl1(MAX_NREQ'(owner), NREQ));
   end

   // The token only ever moves on a release, so it stays one-hot forever
   // once reset has loaded it.
   always_ff @(posedge clk) begin
      if (reset) begin
         token <= {{(NREQ-1){1'b0}}, 1'b1};
      end else if (advance) begin
         token <= token_next;
      end
   end

endmodule

// File: rtl/ring_rr_arbiter.sv
// ring_rr_arbiter
// Round-robin arbiter sharing one resource among NREQ requesters. Priority
// comes from a one-hot ring token; the winner keeps the grant until it drops
// its request or has held it for MAX_HOLD cycles, after which the token moves
// one place past it and one idle cycle follows before the next grant.
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-high
//   req          level request per requester, held until served
//   grant        registered one-hot grant, zero when idle
//   grant_valid  registered OR of grant
//   grant_idx    registered binary index of the owner, 0 when idle
//   timeout      one-cycle pulse when an owner is force-released
module ring_rr_arbiter
   import ring_rr_arbiter_pkg::*;
#(
   parameter int NREQ     = 4,
   parameter int MAX_HOLD = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NREQ-1:0]         req,
   output logic [NREQ-1:0]         grant,
   output logic                    grant_valid,
   output logic [$clog2(NREQ)-1:0] grant_idx,
   output logic                    timeout
);

   localparam int IDXW = $clog2(NREQ);
   localparam int HW   = $clog2(MAX_HOLD + 1);
   localparam logic [HW-1:0]   HOLD_LIMIT = HW'(MAX_HOLD);
   localparam logic [IDXW:0]   NREQ_W     = (IDXW+1)'(NREQ);

   arb_state_t       state, state_n;
   logic [NREQ-1:0]  token;
   logic [HW-1:0]    hold_cnt, hold_n;
   logic [NREQ-1:0]  grant_n;
   logic [IDXW-1:0]  idx_n;
   logic             timeout_n;
   logic             advance;
   logic [IDXW-1:0]  tok_idx;
   logic [NREQ-1:0]  req_rot;
   logic [IDXW-1:0]  first_ofs;
   logic [IDXW:0]    win_sum;
   logic [IDXW-1:0]  win_idx;

   ring_rr_arbiter_token #(
      .NREQ (NREQ)
   ) u_token (
      .clk     (clk),
      .reset   (reset),
      .advance (advance),
      .owner   (grant),
      .token   (token)
   );

   // Wrap-around priority scan: rotate the requests so the token position
   // lands on bit 0, take the lowest set bit, then add the token position
   // back modulo NREQ. The result is only used when some request is set.
   always_comb begin
      tok_idx   = IDXW'(onehot2bin(MAX_NREQ'(token)));
      req_rot   = NREQ'({req, req} >> tok_idx);
      first_ofs = '0;
      for (int j = NREQ - 1; j >= 0; j--) begin
         if (req_rot[j]) begin
            first_ofs = IDXW'(j);
         end
      end
      win_sum = {1'b0, tok_idx} + {1'b0, first_ofs};
      if (win_sum >= NREQ_W) begin
         win_sum = win_sum - NREQ_W;
      end
      win_idx = win_sum[IDXW-1:0];
   end

   // Next-state and next-output logic. Outputs are computed here and then
   // registered, so a grant appears the cycle after its request was sampled.
   // Any release (drop or forced) clears the grant and advances the token,
   // and going through IDLE is what produces the single gap cycle. In BUSY
   // only the owner's request bit is looked at.
   always_comb begin
      state_n   = state;
      grant_n   = grant;
      idx_n     = grant_idx;
      hold_n    = hold_cnt;
      timeout_n = 1'b0;
      advance   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (|req) begin
               grant_n          = '0;
               grant_n[win_idx] = 1'b1;
               idx_n            = win_idx;
               hold_n           = HW'(1);
               state_n          = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if ((req & grant) == '0) begin
               grant_n = '0;
               idx_n   = '0;
               hold_n  = '0;
               advance = 1'b1;
               state_n = ST_IDLE;
            end else if (hold_cnt == HOLD_LIMIT) begin
               grant_n   = '0;
               idx_n     = '0;
               hold_n    = '0;
               timeout_n = 1'b1;
               advance   = 1'b1;
               state_n   = ST_IDLE;
            end else begin
               hold_n = hold_cnt + 1'b1;
            end
         end
         default: begin
            state_n = ST_IDLE;
            grant_n = '0;
            idx_n   = '0;
            hold_n  = '0;
         end
      endcase
   end

   // State and output registers. Reset wins over everything, so a grant in
   // progress is dropped on the very edge reset is seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         grant       <= '0;
         grant_valid <= 1'b0;
         grant_idx   <= '0;
         timeout     <= 1'b0;
         hold_cnt    <= '0;
      end else begin
         state       <= state_n;
         grant       <= grant_n;
         grant_valid <= |grant_n;
         grant_idx   <= idx_n;
         timeout     <= timeout_n;
         hold_cnt    <= hold_n;
      end
   end

endmodule
